// File: rtl/vga_pkg.sv
// Shared definitions for the VGA plot sink: 640x480@60 timing constants,
// framebuffer geometry, the colour type, the controller state encoding and
// small helpers for address and channel generation.
package vga_pkg;

  // Horizontal timing, in pixel-enable ticks (25 MHz pixels).
  localparam logic [9:0] H_VISIBLE = 10'd640;
  localparam logic [9:0] H_FRONT   = 10'd16;
  localparam logic [9:0] H_SYNC    = 10'd96;
  localparam logic [9:0] H_BACK    = 10'd48;
  localparam logic [9:0] H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;  // 800

  // Vertical timing, in lines.
  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] V_FRONT   = 10'd10;
  localparam logic [9:0] V_SYNC    = 10'd2;
  localparam logic [9:0] V_BACK    = 10'd33;
  localparam logic [9:0] V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;  // 525

  // Sync pulse windows, start inclusive and end exclusive.
  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;     // 656
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;   // 752
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;     // 490
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;   // 492

  // Framebuffer geometry: one stored pixel covers a 4x4 screen block.
  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_DEPTH = FB_W * FB_H;  // 19200
  localparam int FB_AW    = 15;

  localparam logic [FB_AW-1:0] FB_LAST = FB_AW'(FB_DEPTH - 1);

  // bit2 = red, bit1 = green, bit0 = blue
  typedef logic [2:0] colour_t;

  localparam colour_t COLOUR_BLACK = 3'b000;

  // Write-side controller: CLEAR only exists when clear-on-reset is built in.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Linear framebuffer address of column col, row row.
  function automatic logic [FB_AW-1:0] fb_addr(input logic [7:0] col,
                                                input logic [7:0] row);
    return FB_AW'(row) * FB_AW'(FB_W) + FB_AW'(col);
  endfunction

  // A colour bit drives its 8-bit channel fully on or fully off.
  function automatic logic [7:0] chan(input logic on);
    return on ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/vga_plot_sink_if.sv
// Plot request bus between a drawing engine (master) and the VGA sink (slave).
interface vga_plot_sink_if;

  // Handshake: the master presents x, y, colour with plot=1; the request is
  // consumed in every cycle where plot=1 and ready=1 (no wait states, no
  // buffering). While ready=0 a raised plot has no effect at all. oob is a
  // sticky status from the slave, set when an accepted request fell outside
  // the 160x120 framebuffer and was dropped.
  logic [8:0]       x;
  logic [8:0]       y;
  vga_pkg::colour_t colour;
  logic             plot;
  logic             ready;
  logic             oob;

  modport master (
    output x, y, colour, plot,
    input  ready, oob
  );

  modport slave (
    input  x, y, colour, plot,
    output ready, oob
  );

endinterface

// File: rtl/vga_framebuffer.sv
// 19200 x 3 simple dual-port RAM: one synchronous write port, one synchronous
// read port. A read and a write to the same address in the same cycle return
// the old contents (read-before-write).
module vga_framebuffer
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [FB_AW-1:0] waddr,
  input  colour_t          wdata,
  input  logic             re,
  input  logic [FB_AW-1:0] raddr,
  output colour_t          rdata
);

  colour_t mem [FB_DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; sees the array before this cycle's write.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_plot_sink.sv
// VGA plot sink: accepts single-pixel plots into a 160x120x3 framebuffer and
// scans it out as 640x480@60 with each stored pixel replicated 4x4.
// Optional feature macro VGA_CLEAR_ON_RESET_EN: after reset the framebuffer
// is filled with black, one address per cycle, while ready is held low.
// Without it, ready is high from the first cycle after reset and the
// framebuffer starts with undefined contents.
module vga_plot_sink
  import vga_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  vga_plot_sink_if.slave        plot_bus,
  output logic [7:0]            vga_r,
  output logic [7:0]            vga_g,
  output logic [7:0]            vga_b,
  output logic                  vga_hs,
  output logic                  vga_vs,
  output logic                  vga_blank_n,
  output state_t                state
);

  // Scan timing
  logic       pix_en;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_last;
  logic       v_last;
  logic       vis_raw;
  logic       hs_raw;
  logic       vs_raw;

  // Read pipeline (stage 1 = RAM read, stage 2 = output register)
  logic [FB_AW-1:0] rd_addr;
  logic             rd_en;
  colour_t          rd_colour;
  logic             hs_d1;
  logic             vs_d1;
  logic             vis_d1;

  // Write side
  state_t           state_q;
  logic             clearing;
  logic [FB_AW-1:0] clr_addr;
  logic             ready_int;
  logic             plot_acc;
  logic             in_range;
  logic [FB_AW-1:0] wr_addr;
  logic             fb_we;
  logic [FB_AW-1:0] fb_waddr;
  colour_t          fb_wdata;
  logic             oob_q;

  // ---------------------------------------------------------------------------
  // Scan timing
  // ---------------------------------------------------------------------------

  // Half-rate pixel enable; first high cycle is the one after reset release.
  always_ff @(posedge clk) begin
    if (reset) pix_en <= 1'b0;
    else       pix_en <= ~pix_en;
  end

  assign h_last = (h_cnt == H_TOTAL - 10'd1);
  assign v_last = (v_cnt == V_TOTAL - 10'd1);

  // Horizontal/vertical position counters, advanced per pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  assign vis_raw = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE);
  assign hs_raw  = !((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END));
  assign vs_raw  = !((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END));

  // Only read inside the visible area; outside it the address would run past
  // the end of the framebuffer and the data is blanked anyway.
  assign rd_addr = fb_addr(h_cnt[9:2], v_cnt[9:2]);
  assign rd_en   = pix_en && vis_raw;

  // Stage 1: syncs and blank travel alongside the RAM read.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_d1  <= 1'b1;
      vs_d1  <= 1'b1;
      vis_d1 <= 1'b0;
    end else if (pix_en) begin
      hs_d1  <= hs_raw;
      vs_d1  <= vs_raw;
      vis_d1 <= vis_raw;
    end
  end

  // Stage 2: output register, channels forced to zero while blanked.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_r       <= 8'h00;
      vga_g       <= 8'h00;
      vga_b       <= 8'h00;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
    end else if (pix_en) begin
      vga_r       <= vis_d1 ? chan(rd_colour[2]) : 8'h00;
      vga_g       <= vis_d1 ? chan(rd_colour[1]) : 8'h00;
      vga_b       <= vis_d1 ? chan(rd_colour[0]) : 8'h00;
      vga_hs      <= hs_d1;
      vga_vs      <= vs_d1;
      vga_blank_n <= vis_d1;
    end
  end

  // ---------------------------------------------------------------------------
  // Write-side controller
  // ---------------------------------------------------------------------------
`ifdef VGA_CLEAR_ON_RESET_EN
  state_t state_d;

  // State register: every reset restarts the clear.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_CLEAR;
    else       state_q <= state_d;
  end

  // Next state: leave CLEAR once the last address has been written.
  always_comb begin
    state_d  = state_q;
    clearing = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clearing = 1'b1;
        if (clr_addr == FB_LAST) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clear pointer, one address per cycle from zero.
  always_ff @(posedge clk) begin
    if (reset)         clr_addr <= '0;
    else if (clearing) clr_addr <= clr_addr + FB_AW'(1);
  end
`else
  assign state_q  = ST_IDLE;
  assign clearing = 1'b0;
  assign clr_addr = '0;
`endif

  assign state = state_q;

  // Plot acceptance: never during reset or clear.
  assign ready_int = !reset && (state_q == ST_IDLE);
  assign plot_acc  = plot_bus.plot && ready_int;
  assign in_range  = (plot_bus.x < 9'(FB_W)) && (plot_bus.y < 9'(FB_H));
  assign wr_addr   = fb_addr(plot_bus.x[7:0], plot_bus.y[7:0]);

  assign fb_we    = !reset && (clearing || (plot_acc && in_range));
  assign fb_waddr = clearing ? clr_addr : wr_addr;
  assign fb_wdata = clearing ? COLOUR_BLACK : plot_bus.colour;

  // Sticky out-of-range flag; only an accepted plot can set it.
  always_ff @(posedge clk) begin
    if (reset)                     oob_q <= 1'b0;
    else if (plot_acc && !in_range) oob_q <= 1'b1;
  end

  assign plot_bus.ready = ready_int;
  assign plot_bus.oob   = oob_q;

  vga_framebuffer u_fb (
    .clk   (clk),
    .we    (fb_we),
    .waddr (fb_waddr),
    .wdata (fb_wdata),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_colour)
  );

endmodule

// File: tb/tb_vga_plot_sink.sv
// Directed bench for vga_plot_sink. A reference model of scan position and
// framebuffer contents predicts every displayed pixel (syncs, blank, colour);
// directed plots then check specific screen pixels against hand-computed
// channel values. Honours VGA_CLEAR_ON_RESET_EN when defined.
`timescale 1ns/1ps
module tb_vga_plot_sink;
  import vga_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;  // 50 MHz

  vga_plot_sink_if plot_bus ();

  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_blank_n;
  state_t     state;

  vga_plot_sink dut (
    .clk         (clk),
    .reset       (reset),
    .plot_bus    (plot_bus),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank_n (vga_blank_n),
    .state       (state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {5'd0, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b};
  endfunction

  function automatic logic [31:0] rgb();
    return {8'd0, vga_r, vga_g, vga_b};
  endfunction

  // Framebuffer model
  colour_t fb_val   [FB_DEPTH];
  bit      fb_known [FB_DEPTH];

  // Posedges since reset was last sampled high
  int rel_cnt = 0;
  always @(posedge clk) begin
    if (reset) rel_cnt <= 0;
    else       rel_cnt <= rel_cnt + 1;
  end

  // ---------------- pixel monitor ----------------
  bit      mon_en = 1'b0;
  int      hs_low = 0;
  int      vis_cnt = 0;
  int      mon_n, mon_h, mon_v, mon_a;
  bit      mon_known;
  colour_t mon_c;
  logic    ehs, evs, evis;
  logic [31:0] mon_exp;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rel_cnt < 4) begin
        check("reset_outputs", outs(), 32'h0600_0000);
        hs_low  = 0;
        vis_cnt = 0;
      end else if (rel_cnt % 2 == 0) begin
        mon_n = (rel_cnt - 4) / 2;
        mon_h = mon_n % 800;
        mon_v = (mon_n / 800) % 525;
        ehs   = !(mon_h >= 656 && mon_h < 752);
        evs   = !(mon_v >= 490 && mon_v < 492);
        evis  = (mon_h < 640) && (mon_v < 480);
        mon_known = 1'b1;
        mon_c     = 3'b000;
        if (evis) begin
          mon_a     = (mon_v / 4) * 160 + mon_h / 4;
          mon_known = fb_known[mon_a];
          mon_c     = fb_val[mon_a];
        end
        if (mon_known) begin
          mon_exp = {5'd0, ehs, evs, evis,
                     (evis && mon_c[2]) ? 8'hFF : 8'h00,
                     (evis && mon_c[1]) ? 8'hFF : 8'h00,
                     (evis && mon_c[0]) ? 8'hFF : 8'h00};
          check($sformatf("pixel h=%0d v=%0d", mon_h, mon_v), outs(), mon_exp);
        end else begin
          check($sformatf("sync h=%0d v=%0d", mon_h, mon_v),
                {29'd0, vga_hs, vga_vs, vga_blank_n}, {29'd0, ehs, evs, evis});
        end
        if (!vga_hs)     hs_low++;
        if (vga_blank_n) vis_cnt++;
        if (mon_h == 799) begin
          check($sformatf("hs_low_line v=%0d", mon_v), hs_low, 96);
          check($sformatf("blank_n_line v=%0d", mon_v), vis_cnt, (mon_v < 480) ? 640 : 0);
          hs_low  = 0;
          vis_cnt = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One accepted plot per call; consecutive calls are back to back.
  task automatic plot_px(input int px, input int py, input logic [2:0] c);
    plot_bus.x      = 9'(px);
    plot_bus.y      = 9'(py);
    plot_bus.colour = c;
    plot_bus.plot   = 1'b1;
    @(posedge clk);
    if (px < 160 && py < 120) begin
      fb_val[py * 160 + px]   = c;
      fb_known[py * 160 + px] = 1'b1;
    end
    @(negedge clk);
    #1;
  endtask

  // Wait (bounded) until the screen shows pixel (ph, pv), sampled #1 after negedge.
  task automatic wait_pixel(input string tag, input int ph, input int pv);
    bit found;
    int n;
    found = 1'b0;
    for (int i = 0; i < 80000 && !found; i++) begin
      @(negedge clk);
      #1;
      if (rel_cnt >= 4 && rel_cnt % 2 == 0) begin
        n = (rel_cnt - 4) / 2;
        if (n % 800 == ph && (n / 800) % 525 == pv) found = 1'b1;
      end
    end
    check({"reach_", tag}, 32'(found), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    plot_bus.x      = '0;
    plot_bus.y      = '0;
    plot_bus.colour = '0;
    plot_bus.plot   = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_outputs", outs(), 32'h0600_0000);
    check("rst_oob", 32'(plot_bus.oob), 32'd0);
    check("rst_ready", 32'(plot_bus.ready), 32'd0);

    // A plot during reset must not set oob.
    plot_bus.x    = 9'd300;
    plot_bus.y    = 9'd3;
    plot_bus.plot = 1'b1;
    @(negedge clk);
    plot_bus.plot = 1'b0;
    #1;
    check("rst_plot_oob", 32'(plot_bus.oob), 32'd0);
    mon_en = 1'b1;

`ifdef VGA_CLEAR_ON_RESET_EN
    for (int i = 0; i < FB_DEPTH; i++) begin
      fb_known[i] = 1'b1;
      fb_val[i]   = 3'b000;
    end
    reset = 1'b0;
    repeat (5000) @(negedge clk);
    #1;
    check("ready_mid_clear", 32'(plot_bus.ready), 32'd0);
    check("state_mid_clear", 32'(state), 32'(ST_CLEAR));
    plot_bus.x    = 9'd300;
    plot_bus.y    = 9'd5;
    plot_bus.plot = 1'b1;
    @(negedge clk);
    plot_bus.plot = 1'b0;
    #1;
    check("clear_plot_oob", 32'(plot_bus.oob), 32'd0);
    // Restart in the middle of the clear.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
`else
    reset = 1'b0;
`endif

    cnt = 0;
    #1;
    while (plot_bus.ready !== 1'b1 && cnt < 30000) begin
`ifdef VGA_CLEAR_ON_RESET_EN
      if (cnt == 3000) begin
        plot_bus.x      = 9'd20;
        plot_bus.y      = 9'd10;
        plot_bus.colour = 3'b111;
        plot_bus.plot   = 1'b1;
      end else begin
        plot_bus.plot = 1'b0;
      end
`endif
      @(negedge clk);
      #1;
      cnt++;
    end
    plot_bus.plot = 1'b0;
`ifdef VGA_CLEAR_ON_RESET_EN
    check("ready_low_cycles", 32'(cnt), 32'd19200);
`else
    check("ready_low_cycles", 32'(cnt), 32'd0);
`endif
    check("state_idle", 32'(state), 32'(ST_IDLE));

    // Directed plots, all to rows not yet on screen.
    plot_px(0, 6, 3'd5);
    plot_px(159, 119, 3'd7);
    plot_bus.plot = 1'b0;
    #1;
    check("oob_inrange_corner", 32'(plot_bus.oob), 32'd0);
    plot_px(160, 5, 3'd2);
    plot_bus.plot = 1'b0;
    #1;
    check("oob_x160", 32'(plot_bus.oob), 32'd1);
    plot_px(10, 10, 3'd1);
    plot_px(159, 10, 3'd7);
    plot_px(105, 9, 3'd2);
    plot_px(105, 9, 3'd3);
    plot_px(5, 120, 3'd6);
    plot_bus.plot = 1'b0;
    #1;
    check("oob_sticky", 32'(plot_bus.oob), 32'd1);
    check("ready_idle", 32'(plot_bus.ready), 32'd1);

    // Screen checks with hand-computed channel values.
    wait_pixel("p0_24", 0, 24);
    check("x160_no_write_0_24", rgb(), 32'h00FF00FF);
    wait_pixel("p420_36", 420, 36);
    check("overwrite_420_36", rgb(), 32'h0000FFFF);
    wait_pixel("p423_39", 423, 39);
    check("overwrite_423_39", rgb(), 32'h0000FFFF);
    wait_pixel("p40_40", 40, 40);
    check("single_40_40", rgb(), 32'h000000FF);
`ifdef VGA_CLEAR_ON_RESET_EN
    wait_pixel("p80_40", 80, 40);
    check("clear_plot_ignored_80_40", rgb(), 32'h00000000);
`endif
    wait_pixel("p636_40", 636, 40);
    check("edge_white_636_40", rgb(), 32'h00FFFFFF);
    wait_pixel("p43_43", 43, 43);
    check("single_43_43", rgb(), 32'h000000FF);
    wait_pixel("p639_43", 639, 43);
    check("edge_white_639_43", rgb(), 32'h00FFFFFF);
    wait_pixel("p640_43", 640, 43);
    check("blank_640_43", outs(), 32'h0600_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_plot_sink.md
VGA_PLOT_SINK -- requirements
Module: vga_plot_sink

Interface
REQ-001 SHALL: clk  input  1  system clock, 50 MHz.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL: x  input  9  plot column, valid range 0..159.
REQ-004 SHALL: y  input  9  plot row, valid range 0..119.
REQ-005 SHALL: colour  input  3  plot colour, bit2=R, bit1=G, bit0=B.
REQ-006 SHALL: plot  input  1  write strobe; one pixel is written per cycle in which plot=1 and ready=1.
REQ-007 SHALL: ready  output  1  the sink accepts plot requests.
REQ-008 SHALL: oob  output  1  sticky flag: an out-of-range plot was dropped.
REQ-009 SHALL: vga_r, vga_g, vga_b  output  8 each  pixel channels.
REQ-010 SHALL: vga_hs, vga_vs  output  1 each  active-low syncs.
REQ-011 SHALL: vga_blank_n  output  1  low outside the visible area.

Function
REQ-012 SHALL: one clock domain; pixel enable pix_en toggles every cycle, giving 25 MHz, and goes high on the first cycle after reset release.
REQ-013 SHALL: h counter 0..799, advanced on pix_en and wrapping 799->0; v counter 0..524, advanced when h wraps and wrapping 524->0.
REQ-014 SHALL: h timing: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-015 SHALL: v timing: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-016 SHALL: framebuffer is 160x120x3; the read address is (v>>2)*160 + (h>>2), so each stored pixel is replicated 4x4 on screen.
REQ-017 SHALL: RAM read latency 1 cycle plus 1 output register; hs, vs and blank are delayed by the same 2 pixel-enables so data and syncs align.
REQ-018 SHALL: each channel is 8'hFF if its colour bit is 1, else 8'h00; all channels are 0 when blanked.
REQ-019 SHALL: write address is y*160 + x; a write occurs on the same cycle as the accepted plot, with no wait states.
REQ-020 SHALL: when x>=160 or y>=120, the write is suppressed and oob is set; oob clears only on reset.
REQ-021 SHALL: a plot to the address currently being read returns the old data for that read; the new data is visible from the next read of that address.
REQ-022 SHALL: plot while ready=0 is ignored, with no write and no oob update.

Reset
REQ-023 SHALL: on reset: h=0, v=0, pix_en=0, oob=0, outputs vga_*=0, vga_hs=1, vga_vs=1, vga_blank_n=0.
REQ-024 SHALL: reset asserted mid-frame or mid-clear restarts timing and the clear from zero on the next cycle.

Configuration
REQ-025 SHALL: macro VGA_CLEAR_ON_RESET_EN.
- Defined: after reset the block writes colour 0 to all 19200 addresses, one per cycle; ready=0 during the clear and rises on the cycle after the last write. FSM states: CLEAR -> IDLE, and reset -> CLEAR. Scan-out runs during the clear.
- Undefined: there is no CLEAR state, ready=1 from the first cycle after reset, and framebuffer contents are undefined.

Structure
REQ-026 SHALL: package vga_pkg holds the timing constants (H/V visible, porch, sync, total), FB_W=160, FB_H=120, FB_DEPTH=19200, and typedef colour_t (logic [2:0]).
REQ-027 SHALL: sub-module vga_framebuffer is a simple dual-port RAM, 19200x3, with a synchronous read port and a write port; no other sub-modules.

Verification
REQ-028 SHALL: Timing check. Run two frames and measure hs low for 96 pixel-enables every 800, and vs low for 2 lines every 525; blank_n is high for 640x480.
REQ-029 SHALL: Single plot. With x=10, y=10, colour=1 and plot pulsed once, screen pixels h=40..43, v=40..43 show vga_b=FF, vga_r=0 and vga_g=0.
REQ-030 SHALL: Boundaries and out-of-range.
- Plot x=159, y=119, colour=7 -> screen pixels h=636..639, v=476..479 are white.
- Then plot x=160, y=5 -> oob=1 and no framebuffer write.
REQ-031 SHALL: Overwrite. Plot x=105, y=9 with colour=2, then the same address with colour=3 on the next cycle -> the following frame shows colour 3 (G=FF, B=FF).
REQ-032 SHALL: Clear with VGA_CLEAR_ON_RESET_EN defined.
- Release reset -> ready=0 for 19200 cycles, then 1; the whole frame is black.
- Plot during the clear is ignored; reset asserted at clear cycle 5000 restarts the full 19200-cycle count.
